decoder_sweep: RTL and testbench
================================

Name: decoder_sweep

Overview:
- Parametrised registered binary-to-one-hot decoder; generalises the fixed 3-to-8 decoder to N index bits and M outputs (M ≤ 2^N).
- Adds a sequential SWEEP mode: a walking-one output advances at a programmable rate, for strobing banks of selects/enables (display digits, row scan, chip-select rotation).
- Sits between control logic and a bank of M select lines; one clock domain.

Parameters:
- N, 3, index input width.
- M, 8, number of one-hot outputs; legal range 2..2^N.
- PERIOD, 1, clock cycles per sweep step; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- E  input  1  enable; gates DIRECT decode, pauses SWEEP.
- I  input  N  index: decode value in DIRECT, start index on a SWEEP start.
- mode  input  1  0 = DIRECT, 1 = SWEEP; sampled only in IDLE.
- start  input  1  single-cycle pulse; launches or relaunches a sweep.
- stop  input  1  single-cycle pulse; aborts a sweep.
- Y  output  M  registered one-hot (or all-zero) select.
- busy  output  1  high while in SWEEP state.
- wrap  output  1  one-cycle pulse when sweep index rolls from M-1 to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: Y=0, busy=0, wrap=0, state=IDLE, idx=0, prescaler=0.
- States: IDLE, SWEEP.
- IDLE, DIRECT decode:
  - Each cycle, Y <= (E && I<M) ? (1<<I) : 0.
  - Latency 1 cycle.
  - I ≥ M gives Y=0.
- IDLE, mode=1 && start && !stop:
  - Go to SWEEP.
  - idx <= (I<M) ? I : 0; prescaler <= 0.
  - Y shows one-hot idx on the next cycle; busy=1 from that same cycle.
- SWEEP with E=1:
  - Prescaler counts 0..PERIOD-1.
  - At PERIOD-1: prescaler <= 0, idx <= (idx==M-1) ? 0 : idx+1.
  - Y follows idx with 1-cycle latency. PERIOD=1 steps every cycle.
- SWEEP with E=0: prescaler, idx and Y hold. No wrap.
- wrap: asserted exactly in the cycle Y first shows bit 0 after a roll from M-1. Not asserted on sweep launch at idx 0.
- start in SWEEP: relaunch; idx reloaded from I (range-checked), prescaler cleared, no wrap.
- stop (any state): next cycle IDLE, Y=0, busy=0, wrap=0.
  - stop wins over a simultaneous start.
  - After stop, DIRECT decode resumes the following cycle.
- mode changes during SWEEP are ignored.
- rst mid-sweep: immediate return to reset values; no pending pulse survives.
- Y is never multi-hot in any state.

Optional Feature:
- Macro DECODER_SWEEP_ONESHOT_EN.
- Defined:
  - A sweep performs exactly one pass.
  - When idx is M-1 and its PERIOD expires, the block returns to IDLE: Y=0 and busy=0 next cycle.
  - wrap pulses in that same cycle, marking pass completion.
- Undefined: the sweep wraps indefinitely until stop, as described above.

Decomposition:
- Package decoder_pkg:
  - mode constants MODE_DIRECT=1'b0, MODE_SWEEP=1'b1.
  - state typedef {IDLE, SWEEP}.
  - prescaler width function (clog2 of PERIOD, minimum 1).
- Sub-module decoder_onehot:
  - Combinational, parameters N and M.
  - Inputs en, idx; output M-bit one-hot with range check.
  - Used for both the DIRECT path and the idx-to-Y path.
- Top holds the FSM, prescaler, idx register and output registers.

Test Plan (N=3, M=6, PERIOD=2 unless stated):
- Reset/DIRECT: assert rst mid-cycle -> Y=0 immediately. Then E=1, mode=0, I=3 -> Y=6'b001000 one cycle later. I=7 -> Y=0. E=0 -> Y=0.
- Sweep launch and step: mode=1, I=4, start pulse -> busy=1, Y=6'b010000 for 2 cycles, then 6'b100000 for 2 cycles, then 6'b000001 with wrap=1 for exactly one cycle.
- Pause and stop: during a sweep, hold E=0 for 5 cycles -> Y unchanged, wrap=0. Then E=1 and resume with the correct remaining count. Then start+stop together -> next cycle Y=0, busy=0.
- Relaunch and range: in SWEEP, start with I=6 -> idx=0, Y=6'b000001, no wrap. PERIOD=1 build -> Y advances every cycle and wrap occurs every 6 cycles.
- Oneshot (DECODER_SWEEP_ONESHOT_EN, I=0):
  - Y walks bits 0..5, 2 cycles each.
  - Then wrap=1, Y=0 and busy=0 in the same cycle.
  - Block stays IDLE.
- Async reset mid-sweep: rst pulse while Y=6'b000100 -> Y=0, busy=0 with no clock edge; after release, DIRECT decode works.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot decoder / sweep block.
// Used by decoder_onehot and decoder_sweep.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SWEEP  = 1'b1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    function automatic int pre_width(input int period);
        if (period > 1)
            return $clog2(period);
        return 1;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// Combinational range-checked binary-to-one-hot decode.
// Index values of M or above decode to all-zero.
module decoder_onehot #(
    parameter int N = 3,
    parameter int M = 8
) (
    input  logic         en,
    input  logic [N-1:0] idx,
    output logic [M-1:0] y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < M; k++)
            y[k] = en && (idx == N'(k));
    end

endmodule

// File: rtl/decoder_sweep.sv
// Registered one-hot decoder with a walking-one SWEEP mode.
// Define DECODER_SWEEP_ONESHOT_EN for single-pass sweeps.
module decoder_sweep
    import decoder_pkg::*;
#(
    parameter int N      = 3,
    parameter int M      = 8,
    parameter int PERIOD = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         E,
    input  logic [N-1:0] I,
    input  logic         mode,
    input  logic         start,
    input  logic         stop,
    output logic [M-1:0] Y,
    output logic         busy,
    output logic         wrap
);

    localparam int PW = pre_width(PERIOD);
    localparam logic [N:0]    M_LIM    = (N+1)'(M);
    localparam logic [N-1:0]  LAST     = N'(M - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PERIOD - 1);

    state_t        state;
    logic [N-1:0]  idx;
    logic [PW-1:0] pre;

    logic [N-1:0]  load_idx;
    logic [N-1:0]  step_idx;
    logic [N-1:0]  sel_idx;
    logic [M-1:0]  y_direct;
    logic [M-1:0]  y_sweep;
    logic          launch;
    logic          direct_en;

    assign load_idx  = ({1'b0, I} < M_LIM) ? I : '0;
    assign step_idx  = (idx == LAST) ? '0 : idx + 1'b1;
    // mode only matters in IDLE; a start in SWEEP always relaunches
    assign launch    = start &&
                       (state == SWEEP || mode == MODE_SWEEP);
    assign sel_idx   = launch ? load_idx : step_idx;
    assign direct_en = E && (mode == MODE_DIRECT);

    decoder_onehot #(.N(N), .M(M)) u_direct (
        .en  (direct_en),
        .idx (I),
        .y   (y_direct)
    );

    decoder_onehot #(.N(N), .M(M)) u_sweep (
        .en  (1'b1),
        .idx (sel_idx),
        .y   (y_sweep)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            pre   <= '0;
            Y     <= '0;
            busy  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (stop) begin
                state <= IDLE;
                idx   <= '0;
                pre   <= '0;
                Y     <= '0;
                busy  <= 1'b0;
            end else if (launch) begin
                state <= SWEEP;
                idx   <= load_idx;
                pre   <= '0;
                Y     <= y_sweep;
                busy  <= 1'b1;
            end else if (state == IDLE) begin
                Y <= y_direct;
            end else if (E) begin
                if (pre == PRE_LAST) begin
                    pre <= '0;
`ifdef DECODER_SWEEP_ONESHOT_EN
                    if (idx == LAST) begin
                        state <= IDLE;
                        idx   <= '0;
                        Y     <= '0;
                        busy  <= 1'b0;
                        wrap  <= 1'b1;
                    end else begin
                        idx <= step_idx;
                        Y   <= y_sweep;
                    end
`else
                    idx  <= step_idx;
                    Y    <= y_sweep;
                    wrap <= (idx == LAST);
`endif
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_decoder_sweep.sv
// Directed bench for decoder_sweep (N=3, M=6, PERIOD=2 and PERIOD=1).
// Build with DECODER_SWEEP_ONESHOT_EN to exercise single-pass sweeps.
module tb_decoder_sweep;

    logic       clk;
    logic       rst;
    logic       E;
    logic [2:0] I;
    logic       mode;
    logic       start;
    logic       stop;
    logic [5:0] Y;
    logic       busy;
    logic       wrap;
    logic [5:0] Y1;
    logic       busy1;
    logic       wrap1;

    int pass_cnt;
    int total_cnt;

    decoder_sweep #(.N(3), .M(6), .PERIOD(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .I     (I),
        .mode  (mode),
        .start (start),
        .stop  (stop),
        .Y     (Y),
        .busy  (busy),
        .wrap  (wrap)
    );

    decoder_sweep #(.N(3), .M(6), .PERIOD(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .E     (E),
        .I     (I),
        .mode  (mode),
        .start (start),
        .stop  (stop),
        .Y     (Y1),
        .busy  (busy1),
        .wrap  (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; E = 1'b0; I = '0;
        mode = 1'b0; start = 1'b0; stop = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (Y !== 6'b0 || busy !== 1'b0 || wrap !== 1'b0)
            $display("FAIL reset: Y=%b busy=%b wrap=%b want 0/0/0",
                     Y, busy, wrap);
        else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_direct();
        E = 1'b1; mode = 1'b0; I = 3'd3;
        tick();
        total_cnt++;
        if (Y !== 6'b001000 || busy !== 1'b0)
            $display("FAIL direct_i3: Y=%b busy=%b want 001000/0",
                     Y, busy);
        else pass_cnt++;
        I = 3'd7;
        tick();
        total_cnt++;
        if (Y !== 6'b0)
            $display("FAIL direct_i7: Y=%b want 000000", Y);
        else pass_cnt++;
        I = 3'd5;
        tick();
        total_cnt++;
        if (Y !== 6'b100000)
            $display("FAIL direct_i5: Y=%b want 100000", Y);
        else pass_cnt++;
        E = 1'b0; I = 3'd2;
        tick();
        total_cnt++;
        if (Y !== 6'b0)
            $display("FAIL direct_e0: Y=%b want 000000", Y);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [5:0] exp_y [6];
        logic       exp_w [6];
        exp_y = '{6'b010000, 6'b010000, 6'b100000,
                  6'b100000, 6'b000001, 6'b000001};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        E = 1'b1; mode = 1'b1; I = 3'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            total_cnt++;
            if (Y !== exp_y[k] || wrap !== exp_w[k] || busy !== 1'b1)
                $display("FAIL sweep_step%0d: Y=%b wrap=%b busy=%b want %b/%b/1",
                         k, Y, wrap, busy, exp_y[k], exp_w[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause_stop();
        tick();
        total_cnt++;
        if (Y !== 6'b000010)
            $display("FAIL pause_pre: Y=%b want 000010", Y);
        else pass_cnt++;
        E = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total_cnt++;
            if (Y !== 6'b000010 || wrap !== 1'b0)
                $display("FAIL pause_hold%0d: Y=%b wrap=%b want 000010/0",
                         k, Y, wrap);
            else pass_cnt++;
        end
        E = 1'b1;
        tick();
        total_cnt++;
        if (Y !== 6'b000010)
            $display("FAIL resume_rem: Y=%b want 000010", Y);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (Y !== 6'b000100)
            $display("FAIL resume_step: Y=%b want 000100", Y);
        else pass_cnt++;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        total_cnt++;
        if (Y !== 6'b0 || busy !== 1'b0 || wrap !== 1'b0)
            $display("FAIL stop_wins: Y=%b busy=%b wrap=%b want 0/0/0",
                     Y, busy, wrap);
        else pass_cnt++;
        mode = 1'b0; I = 3'd2;
        tick();
        total_cnt++;
        if (Y !== 6'b000100 || busy !== 1'b0)
            $display("FAIL post_stop_direct: Y=%b busy=%b want 000100/0",
                     Y, busy);
        else pass_cnt++;
    endtask

    task automatic test_relaunch();
        mode = 1'b1; I = 3'd1; start = 1'b1;
        tick();
        total_cnt++;
        if (Y !== 6'b000010 || busy !== 1'b1)
            $display("FAIL relaunch_first: Y=%b busy=%b want 000010/1",
                     Y, busy);
        else pass_cnt++;
        I = 3'd6;
        tick();
        start = 1'b0;
        mode = 1'b0;
        total_cnt++;
        if (Y !== 6'b000001 || wrap !== 1'b0 || busy !== 1'b1)
            $display("FAIL relaunch_range: Y=%b wrap=%b busy=%b want 000001/0/1",
                     Y, wrap, busy);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (Y !== 6'b000010 || busy !== 1'b1)
            $display("FAIL mode_ignored: Y=%b busy=%b want 000010/1",
                     Y, busy);
        else pass_cnt++;
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_period1();
        logic [5:0] ey;
        mode = 1'b1; I = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (Y1 !== 6'b000001 || wrap1 !== 1'b0 || busy1 !== 1'b1)
            $display("FAIL p1_launch: Y=%b wrap=%b busy=%b want 000001/0/1",
                     Y1, wrap1, busy1);
        else pass_cnt++;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ey = 6'b1 << (k % 6);
            total_cnt++;
            if (Y1 !== ey || wrap1 !== (k % 6 == 0))
                $display("FAIL p1_step%0d: Y=%b wrap=%b want %b/%b",
                         k, Y1, wrap1, ey, (k % 6 == 0));
            else pass_cnt++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [5:0] ey;
        E = 1'b1; mode = 1'b1; I = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            ey = 6'b1 << b;
            for (int c = 0; c < 2; c++) begin
                if (b > 0 || c > 0) tick();
                total_cnt++;
                if (Y !== ey || busy !== 1'b1 || wrap !== 1'b0)
                    $display("FAIL os_walk%0d_%0d: Y=%b busy=%b wrap=%b want %b/1/0",
                             b, c, Y, busy, wrap, ey);
                else pass_cnt++;
            end
        end
        tick();
        total_cnt++;
        if (Y !== 6'b0 || busy !== 1'b0 || wrap !== 1'b1)
            $display("FAIL os_done: Y=%b busy=%b wrap=%b want 0/0/1",
                     Y, busy, wrap);
        else pass_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt++;
            if (Y !== 6'b0 || busy !== 1'b0 || wrap !== 1'b0)
                $display("FAIL os_idle%0d: Y=%b busy=%b wrap=%b want 0/0/0",
                         k, Y, busy, wrap);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        E = 1'b1; mode = 1'b1; I = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if (Y !== 6'b000100 || busy !== 1'b1)
            $display("FAIL ar_pre: Y=%b busy=%b want 000100/1", Y, busy);
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (Y !== 6'b0 || busy !== 1'b0 || wrap !== 1'b0)
            $display("FAIL ar_async: Y=%b busy=%b wrap=%b want 0/0/0",
                     Y, busy, wrap);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        mode = 1'b0; I = 3'd1;
        tick();
        total_cnt++;
        if (Y !== 6'b000010 || busy !== 1'b0 || wrap !== 1'b0)
            $display("FAIL ar_direct: Y=%b busy=%b wrap=%b want 000010/0/0",
                     Y, busy, wrap);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_direct();
`ifdef DECODER_SWEEP_ONESHOT_EN
        test_oneshot();
`else
        test_sweep();
        test_pause_stop();
        test_relaunch();
        test_period1();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
